// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Exports the FSM state enum, the default memory depth and an index-width helper.
package imem_loader_pkg;

    localparam int DEPTH_DEF = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    // One extra bit so the index can reach DEPTH itself.
    function automatic int idx_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs serial bytes into a little-endian 32-bit word, lane 0 first.
// Ports: clr restarts at lane 0; in_valid/in_data feed a byte; word is valid with word_complete.
module byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic [1:0]  lane,
    output logic        word_complete
);

    // Holds lanes 0..2; lane 3 comes straight from in_data.
    logic [23:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            lane <= '0;
        end else if (clr) begin
            sh   <= '0;
            lane <= '0;
        end else if (in_valid) begin
            sh   <= {in_data, sh[23:8]};
            lane <= lane + 2'd1;
        end
    end

    assign word          = {in_data, sh};
    assign word_complete = in_valid && (lane == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed image into instruction memory.
// Ports: start, rx_valid/rx_data/rx_ready in; we/wa/wd write port; cpu_rst_n, busy, done, err.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        we,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int          IW      = idx_width(DEPTH);
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    state_t          state;
    state_t          state_n;
    logic [7:0]      csum;
    logic [7:0]      len_lo;
    logic [15:0]     len;
    logic [15:0]     len_n;
    logic [IW-1:0]   idx;
    logic            acc;
    logic            take;
    logic            last_word;
    logic            pk_valid;
    logic [31:0]     pk_word;
    logic [1:0]      pk_lane;
    logic            pk_done;

    assign acc       = rx_valid && rx_ready;
    assign len_n     = {rx_data, len_lo};
    assign last_word = ({{(16-IW){1'b0}}, idx} + 16'd1) == len;
    assign take      = start && !busy;
    assign pk_valid  = acc && (state == S_DATA);

    byte_packer u_pack (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr           (take),
        .in_valid      (pk_valid),
        .in_data       (rx_data),
        .word          (pk_word),
        .lane          (pk_lane),
        .word_complete (pk_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) state_n = S_LEN0;
            end
            S_LEN0: begin
                if (acc) state_n = S_LEN1;
            end
            S_LEN1: begin
                if (acc) begin
                    if (len_n == 16'd0)      state_n = S_CSUM;
                    else if (len_n > DEPTH16) state_n = S_ERR;
                    else                      state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (pk_done && last_word) state_n = S_CSUM;
            end
            S_CSUM: begin
                if (acc) state_n = (rx_data == csum) ? S_DONE : S_ERR;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum   <= '0;
            len_lo <= '0;
            len    <= '0;
            idx    <= '0;
            we     <= 1'b0;
            wa     <= '0;
            wd     <= '0;
        end else begin
            we <= 1'b0;
            if (take) begin
                csum <= '0;
                idx  <= '0;
            end else if (acc && state != S_CSUM) begin
                csum <= csum ^ rx_data;
                if (state == S_LEN0) len_lo <= rx_data;
                if (state == S_LEN1) len    <= len_n;
                if (pk_done) begin
                    we  <= 1'b1;
                    wa  <= {{(30-IW){1'b0}}, idx, 2'b00};
                    wd  <= pk_word;
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign busy      = (state == S_LEN0) || (state == S_LEN1) ||
                       (state == S_DATA) || (state == S_CSUM);
    assign rx_ready  = busy;
    assign cpu_rst_n = (state == S_DONE);
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader.
// Driver queues expected writes; a negedge monitor pops and compares each we pulse.
module tb_imem_loader;

    localparam int DEPTH = 64;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] wbuf[0:DEPTH];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_rx_ready", 32'(rx_ready), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_wa", wa, 0);
        chk("rst_wd", wd, 0);
        chk("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
    endtask

    // Monitor: every write pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n && we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wa", wa, e.a);
                chk("wd", wd, e.d);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            chk("rx_ready_timeout", 0, 1);
        end else begin
            @(posedge clk);
        end
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) wbuf[i] = $urandom;
    endtask

    // Reference: build the wire image from the word list, predict writes and outcome.
    task automatic run_session(input int n, input logic [7:0] bad,
                               input bit gaps, input bit mid_start);
        logic [7:0]  bytes[$];
        logic [7:0]  x;
        logic [15:0] n16;
        logic [31:0] w;
        bit          good;
        n16 = 16'(n);
        bytes.push_back(n16[7:0]);
        bytes.push_back(n16[15:8]);
        if (n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                w = wbuf[i];
                for (int l = 0; l < 4; l++) bytes.push_back(w[8*l +: 8]);
                exp_q.push_back('{a: 32'(4 * i), d: w});
            end
            x = 8'h00;
            foreach (bytes[k]) x = x ^ bytes[k];
            bytes.push_back(x ^ bad);
        end
        good = (n <= DEPTH) && (bad == 8'h00);
        pulse_start();
        for (int k = 0; k < bytes.size(); k++) begin
            if (gaps && ($urandom % 3 == 0))
                repeat ($urandom_range(1, 3)) @(negedge clk);
            if (mid_start && k == 4) pulse_start();
            send_byte(bytes[k]);
            if (k >= 2 && k < 2 + 4 * n && ((k - 2) % 4) == 3)
                chk("we_timing", 32'(we), 1);
        end
        @(negedge clk);
        chk("done", 32'(done), 32'(good));
        chk("err", 32'(err), 32'(!good));
        chk("cpu_rst_n", 32'(cpu_rst_n), 32'(good));
        chk("busy_end", 32'(busy), 0);
        chk("rx_ready_end", 32'(rx_ready), 0);
        repeat (2) @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        chk_reset_outs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Two-word image, correct checksum 0xFD.
        wbuf[0] = 32'h0000000F;
        wbuf[1] = 32'h000000F0;
        run_session(2, 8'h00, 1'b0, 1'b0);

        // Same image, checksum byte 0x00.
        run_session(2, 8'hFD, 1'b0, 1'b0);

        // Length one past capacity.
        run_session(DEPTH + 1, 8'h00, 1'b0, 1'b0);

        // Empty image.
        run_session(0, 8'h00, 1'b0, 1'b0);

        // Gaps between bytes plus a start pulse mid-session.
        fill_random(2);
        run_session(2, 8'h00, 1'b1, 1'b1);

        // Reset after two data bytes, then a clean reload.
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outs();
        @(negedge clk);
        rst_n = 1'b1;
        fill_random(3);
        run_session(3, 8'h00, 1'b1, 1'b0);

        // Full-capacity image.
        fill_random(DEPTH);
        run_session(DEPTH, 8'h00, 1'b1, 1'b0);

        // Random sessions.
        for (int s = 0; s < 6; s++) begin
            int n;
            n = $urandom_range(1, 8);
            fill_random(n);
            run_session(n, ($urandom % 2 == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
                        1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader that streams a program from a byte-serial source (UART RX or debug link) into the instruction memory's write port, holding the core in reset until the image is complete and verified. Sits between the serial receiver and the instruction memory in the single-cycle RV32I top level. It owns the instruction memory during load and releases the core only after a checksum-verified image.

## Interface
- DEPTH, 64: instruction memory size in 32-bit words; maximum accepted image length.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load session from IDLE, DONE or ERR.
- rx_valid  in  1  byte available on rx_data.
- rx_data  in  8  serial byte.
- rx_ready  out  1  loader can accept a byte; a byte transfers on rx_valid && rx_ready.
- we  out  1  instruction memory write enable, one-cycle pulse per word.
- wa  out  32  byte address of the word written, always word-aligned (wa[1:0]=0).
- wd  out  32  word written.
- cpu_rst_n  out  1  core reset, active-low; low whenever no verified image is loaded.
- busy  out  1  session in progress.
- done  out  1  image loaded and checksum passed; level, held until next start.
- err  out  1  length or checksum error; level, held until next start.

## Operation
- Wire format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes (each word little-endian, word 0 first), then one CSUM byte.
- Checksum: running XOR of every byte from LEN_LO through the last data byte; the CSUM byte must equal it.
- States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR --start--> LEN0; clear checksum, word index, byte lane, done, err; drive cpu_rst_n low.
- LEN0 --byte--> LEN1 (latch low byte).
- LEN1 --byte--> N==0: CSUM; N>DEPTH: ERR; else DATA.
- DATA: each byte fills lane 0..3; on lane 3, the assembled word is written at index i, i increments and lane returns to 0; after word N-1, go to CSUM.
- CSUM --byte--> match: DONE; mismatch: ERR.
- rx_ready = 1 only in LEN0, LEN1, DATA, CSUM; 0 in IDLE, DONE, ERR.
- start while busy is ignored.
- busy = 1 in LEN0, LEN1, DATA, CSUM.
- cpu_rst_n = 1 only in DONE.
- Words already written before an error are left in memory; the core stays in reset.
- Index width is clog2(DEPTH)+1; wa = {index, 2'b00} zero-extended to 32 bits.

## Timing
- Reset values: state IDLE, rx_ready 0, we 0, wa 0, wd 0, cpu_rst_n 0, busy 0, done 0, err 0.
- Reset asserted mid-session aborts immediately to IDLE; no partial word is written.
- we, wa and wd are registered and asserted the cycle after the fourth byte of a word is accepted. Maximum throughput is one byte per cycle, so successive we pulses are spaced at least 4 cycles apart.
- done/err and cpu_rst_n update on the cycle after the CSUM byte, or the failing LEN_HI byte, is accepted.
- start and an accepted byte cannot coincide: rx_ready is 0 in every state where start is honoured.

## Structure
- Package imem_loader_pkg: state enum, DEPTH default, and a function returning the index width.
- Sub-module byte_packer: shifts bytes into a 32-bit little-endian word, tracks the 2-bit lane, and flags word_complete. Checksum, counting and FSM stay in imem_loader.

## Test plan
- Load N=2 with words 0x0000000F and 0x000000F0. Bytes: 02 00 0F 00 00 00 F0 00 00 00, CSUM = 0x02^0x0F^0xF0 = 0xFD. Expect we at wa=0 with wd=0x0000000F, then wa=4 with wd=0x000000F0; then done=1, cpu_rst_n=1, err=0.
- Same stream with CSUM=0x00. Expect both writes, err=1, done=0, cpu_rst_n=0.
- LEN = DEPTH+1 (0x41 0x00). Expect err=1 the cycle after LEN_HI, no we pulses, rx_ready=0.
- N=0, CSUM=0x00. Expect no we pulses, then done=1.
- Deassert rx_valid between bytes of the first word, and pulse start mid-session. Expect no extra writes, correct data, and start ignored.
- Assert rst_n=0 after 2 data bytes. Expect all outputs at reset values immediately. Then start a new session and load a full image successfully.
